// File: rtl/event_counters.sv
// Bank of N_CNT independent event counters with load, soft clear and overflow handling.
// Define PMU_OVF_INTR_EN for wrap + sticky overflow/interrupt; otherwise counters saturate.

module event_counter_lane #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             inc,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic at_max;
  assign at_max = (cnt == {CNT_W{1'b1}});

  // clear beats write beats increment; a dropped event is never deferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (wr_hit)           cnt <= wr_data;
`ifdef PMU_OVF_INTR_EN
    else if (inc)              cnt <= cnt + CNT_W'(1);
`else
    else if (inc && !at_max)   cnt <= cnt + CNT_W'(1);
`endif
  end

`ifdef PMU_OVF_INTR_EN
  logic wrap;
  assign wrap = inc && !wr_hit && at_max;

  // a wrap in the same cycle as a flag clear leaves the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (clear)   ovf <= 1'b0;
    else if (wrap)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

module event_counters #(
  parameter  int N_CNT      = 24,
  parameter  int CNT_W      = 32,
  localparam int N_BITS_IDX = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [0:N_CNT-1]                  events_i,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic                              we_i,
  input  logic [N_BITS_IDX-1:0]             wr_idx_i,
  input  logic [CNT_W-1:0]                  wr_data_i,
  input  logic [N_CNT-1:0]                  ovf_mask_i,
  input  logic [N_CNT-1:0]                  ovf_clr_i,
  output logic [0:N_CNT-1][CNT_W-1:0]       cnt_o,
  output logic [N_CNT-1:0]                  ovf_o,
  output logic                              intr_o
);

  typedef struct packed {
    logic                  we;
    logic [N_BITS_IDX-1:0] idx;
    logic [CNT_W-1:0]      data;
  } wr_req_t;

  wr_req_t wr_req;
  assign wr_req = '{we: we_i, idx: wr_idx_i, data: wr_data_i};

  // an out-of-range index matches no lane, so the write is simply lost
  for (genvar x = 0; x < N_CNT; x++) begin : g_lane
    logic wr_hit;
    assign wr_hit = wr_req.we && (wr_req.idx == N_BITS_IDX'(x));

    event_counter_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk_i),
      .rst     (rst_i),
      .clear   (clear_i),
      .wr_hit  (wr_hit),
      .wr_data (wr_req.data),
      .inc     (en_i && events_i[x]),
      .ovf_clr (ovf_clr_i[x]),
      .cnt     (cnt_o[x]),
      .ovf     (ovf_o[x])
    );
  end

`ifdef PMU_OVF_INTR_EN
  assign intr_o = |(ovf_o & ovf_mask_i);
`else
  logic unused_ovf_mask;
  assign unused_ovf_mask = ^ovf_mask_i;
  assign intr_o = 1'b0;
`endif

endmodule

// File: tb/tb_event_counters.sv
// Randomised self-checking bench for event_counters against a behavioural model.
// Follows PMU_OVF_INTR_EN to pick wrap or saturate expectations.

module tb_event_counters;
  localparam int N = 24;
  localparam int W = 32;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, clear, we;
  logic [4:0]       wr_idx;
  logic [W-1:0]     wr_data;
  logic [0:N-1]     events;
  logic [N-1:0]     mask, oclr;
  logic [0:N-1][W-1:0] cnt;
  logic [N-1:0]     ovf;
  logic             intr;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  logic [W-1:0] mcnt [N];
  logic [N-1:0] movf;

  always #5 clk = ~clk;

  event_counters #(.N_CNT(N), .CNT_W(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .events_i   (events),
    .en_i       (en),
    .clear_i    (clear),
    .we_i       (we),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .ovf_mask_i (mask),
    .ovf_clr_i  (oclr),
    .cnt_o      (cnt),
    .ovf_o      (ovf),
    .intr_o     (intr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: apply the priority rules to each counter as plain integers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int x = 0; x < N; x++) mcnt[x] = '0;
      movf = '0;
    end else begin
      for (int x = 0; x < N; x++) begin
        longint v;
        bit     set_f;
        set_f = 1'b0;
        if (clear) begin
          mcnt[x] = '0;
          movf[x] = 1'b0;
        end else begin
          if (we && (int'(wr_idx) == x)) mcnt[x] = wr_data;
          else if (en && events[x]) begin
            v = longint'(mcnt[x]) + 1;
`ifdef PMU_OVF_INTR_EN
            if (v > MAXV) begin mcnt[x] = '0; set_f = 1'b1; end
            else mcnt[x] = W'(v);
`else
            if (v <= MAXV) mcnt[x] = W'(v);
`endif
          end
`ifdef PMU_OVF_INTR_EN
          if (set_f) movf[x] = 1'b1;
          else if (oclr[x]) movf[x] = 1'b0;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      for (int x = 0; x < N; x++) chk($sformatf("cnt[%0d]", x), 64'(cnt[x]), 64'(mcnt[x]));
      chk("ovf", 64'(ovf), 64'(movf));
      chk("intr", 64'(intr), 64'(|(movf & mask)));
    end
  end

  task automatic idle();
    en = 1'b0; clear = 1'b0; we = 1'b0; wr_idx = '0; wr_data = '0;
    events = '0; mask = '0; oclr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit others_zero(input int keep);
    bit ok;
    ok = 1'b1;
    for (int x = 0; x < N; x++) if (x != keep && cnt[x] !== '0) ok = 1'b0;
    return ok;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_all_cnt_zero", 64'(others_zero(-1)), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_intr", 64'(intr), 64'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_cnt_zero", 64'(others_zero(-1)), 64'd1);
    chk("reset_ovf", 64'(ovf), 64'd0);
    run = 1'b1;

    // Count five events on counter 3, then freeze with en low.
    en = 1'b1; events[3] = 1'b1;
    repeat (5) tick();
    chk("count_cnt3", 64'(cnt[3]), 64'd5);
    chk("count_others", 64'(others_zero(3)), 64'd1);
    en = 1'b0;
    repeat (3) tick();
    chk("freeze_cnt3", 64'(cnt[3]), 64'd5);

    // Reset mid-count, between clock edges.
    en = 1'b1;
    tick();
    reset_pulse();
    tick();
    chk("post_rst_cnt3", 64'(cnt[3]), 64'd1);
    idle();

    // Priority: clear wins over write and event, then write wins over event.
    clear = 1'b1; we = 1'b1; wr_idx = 5'd2; wr_data = 32'h10; en = 1'b1; events[2] = 1'b1;
    tick();
    chk("prio_clear", 64'(cnt[2]), 64'd0);
    clear = 1'b0;
    tick();
    chk("prio_write", 64'(cnt[2]), 64'h10);
    idle();

    // Near-max behaviour on counter 7.
    we = 1'b1; wr_idx = 5'd7; wr_data = 32'hFFFF_FFFE;
    tick();
    idle();
    en = 1'b1; events[7] = 1'b1; mask[7] = 1'b1;
`ifdef PMU_OVF_INTR_EN
    repeat (2) tick();
    chk("wrap_cnt7", 64'(cnt[7]), 64'd0);
    chk("wrap_ovf7", 64'(ovf[7]), 64'd1);
    chk("wrap_intr", 64'(intr), 64'd1);
    en = 1'b0; events = '0; oclr[7] = 1'b1;
    tick();
    chk("oclr_ovf7", 64'(ovf[7]), 64'd0);
    chk("oclr_intr", 64'(intr), 64'd0);
`else
    repeat (3) tick();
    chk("sat_cnt7", 64'(cnt[7]), 64'hFFFF_FFFF);
    chk("sat_ovf", 64'(ovf), 64'd0);
    chk("sat_intr", 64'(intr), 64'd0);
`endif
    idle();

    // Flag set beats simultaneous flag clear on counter 0.
    we = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    idle();
    en = 1'b1; events[0] = 1'b1; oclr[0] = 1'b1;
    tick();
`ifdef PMU_OVF_INTR_EN
    chk("corner_ovf0", 64'(ovf[0]), 64'd1);
    chk("corner_cnt0", 64'(cnt[0]), 64'd0);
`else
    chk("corner_cnt0", 64'(cnt[0]), 64'hFFFF_FFFF);
`endif
    idle();

    // Out-of-range write index touches nothing.
    we = 1'b1; wr_idx = 5'd30; wr_data = 32'h1234_5678;
    tick();
    chk("oob_cnt2", 64'(cnt[2]), 64'h10);
    chk("oob_cnt3", 64'(cnt[3]), 64'd0);
    idle();

    // Random traffic; writes bias toward near-max to exercise wrap/saturation.
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      events  = N'($urandom);
      clear   = ($urandom_range(0, 99) == 0);
      we      = ($urandom_range(0, 2) == 0);
      wr_idx  = 5'($urandom);
      wr_data = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFF - W'($urandom_range(0, 2))) : $urandom;
      mask    = N'($urandom);
      oclr    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      tick();
      if (i == 300) reset_pulse();
    end

    idle();
    tick();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_counters.md
EVENT_COUNTERS -- requirements
Module: event_counters

Interface
REQ-001 Parameter N_CNT, default 24: number of counters; equals crossbar N_OUT.
REQ-002 Parameter CNT_W, default 32: counter width in bits, legal range 2..64.
REQ-003 Localparam N_BITS_IDX = $clog2(N_CNT): width of the counter index.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 events_i  in  1 x [0:N_CNT-1]  registered event bits from crossbar vector_o; element x drives counter x.
REQ-007 en_i  in  1  global count enable.
REQ-008 clear_i  in  1  synchronous soft clear of all counters and overflow flags.
REQ-009 we_i  in  1  counter write strobe.
REQ-010 wr_idx_i  in  N_BITS_IDX  target counter of the write.
REQ-011 wr_data_i  in  CNT_W  value loaded by the write.
REQ-012 ovf_mask_i  in  N_CNT  per-counter interrupt enable, bit x for counter x.
REQ-013 ovf_clr_i  in  N_CNT  per-counter write-1-to-clear of the overflow flag.
REQ-014 cnt_o  out  CNT_W x [0:N_CNT-1]  registered counter values.
REQ-015 ovf_o  out  N_CNT  registered sticky overflow flags.
REQ-016 intr_o  out  1  overflow interrupt.

Function
REQ-017 Per counter x, each rising edge SHALL apply exactly one action, highest priority first: clear_i=1 -> 0; we_i=1 and wr_idx_i==x -> wr_data_i; en_i=1 and events_i[x]=1 -> increment by 1; otherwise hold.
REQ-018 An increment SHALL be +1 per cycle at most; an event coinciding with a write or clear to the same counter SHALL be dropped, not deferred.
REQ-019 Latency: an event sampled at edge n SHALL be visible on cnt_o immediately after edge n; no further pipelining.
REQ-020 A write with wr_idx_i >= N_CNT SHALL have no effect on any counter or flag.
REQ-021 Writes SHALL NOT modify ovf_o.
REQ-022 intr_o SHALL equal the OR over x of (ovf_o[x] AND ovf_mask_i[x]), combinational from registered flags, so it rises in the same cycle ovf_o sets.
REQ-023 Overflow flag x next value, priority first: clear_i=1 -> 0; wrap-set event (REQ-030) -> 1; ovf_clr_i[x]=1 -> 0; otherwise hold; set SHALL win over a simultaneous ovf_clr_i.
REQ-024 en_i=0 SHALL freeze counting only; writes, clears and flag clears remain active.
REQ-025 Counters SHALL be independent; simultaneous events on all N_CNT counters SHALL all count in the same cycle.

Reset
REQ-026 Asserting rst_i SHALL clear every counter, ovf_o and intr_o to 0 immediately, without waiting for a clock edge.
REQ-027 rst_i asserted mid-operation SHALL discard any in-flight write or event; counting resumes on the first edge after deassertion.
REQ-028 rst_i deassertion is synchronised externally; the block does not re-synchronise it.

Configuration
REQ-029 Macro PMU_OVF_INTR_EN selects the overflow feature.
REQ-030 With PMU_OVF_INTR_EN defined: an increment from all-ones SHALL wrap to 0 and set ovf_o[x] on that edge.
REQ-031 Without PMU_OVF_INTR_EN: counters SHALL saturate at all-ones and ignore further increments; ovf_o and intr_o SHALL be constant 0; ovf_mask_i and ovf_clr_i are unused.

Verification (N_CNT=24, CNT_W=32)
REQ-032 Reset: rst_i pulse mid-count, no clock edge during the pulse -> cnt_o all 0, ovf_o=0, intr_o=0 while rst_i is high.
REQ-033 Count: en_i=1, events_i[3]=1 for 5 cycles -> cnt_o[3]=5, all other counters 0; en_i=0 for 3 further event cycles -> cnt_o[3] stays 5.
REQ-034 Wrap (macro defined): write 0xFFFFFFFE to counter 7, then 2 events with ovf_mask_i[7]=1 -> cnt_o[7]=0, ovf_o[7]=1, intr_o=1; ovf_clr_i[7]=1 pulse -> ovf_o[7]=0, intr_o=0.
REQ-035 Saturate (macro undefined): write 0xFFFFFFFE to counter 7, then 3 events -> cnt_o[7]=0xFFFFFFFF, ovf_o=0, intr_o=0.
REQ-036 Priority: same cycle clear_i=1, we_i=1 to index 2 with 0x10, events_i[2]=1 -> cnt_o[2]=0; next cycle we_i plus event on index 2 with 0x10 -> cnt_o[2]=0x10.
REQ-037 Corner: ovf_clr_i[0]=1 in the wrap cycle of counter 0 -> ovf_o[0]=1; write with wr_idx_i=30 -> no counter changes.
